alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one 16-bit flag-producing adder (z = x + y, plus sign/zero/parity/carry/overflow)
//  between two requesters. Arbitration is round-robin.
//  Accepted operands are added and the result is registered into a single-entry response buffer.
//  The response carries the requester ID and the result, and is held under valid/ready backpressure.
//  Sits between two client sequencers and the shared adder datapath.
// PARAMETERS
//  PRIO_INIT  1'b0  requester that wins the first simultaneous request after reset
// PORTS
//  clk        in   1   single clock; all state on rising edge
//  rst        in   1   asynchronous, active-high reset
//  req_valid  in   2   bit i: requester i presents operands
//  req_ready  out  2   bit i: requester i's operands accepted this cycle (one-hot or 0)
//  x0, y0     in   16  requester 0 operands
//  x1, y1     in   16  requester 1 operands
//  rsp_valid  out  1   response buffer holds a result
//  rsp_ready  in   1   consumer accepts the response this cycle
//  rsp_id     out  1   requester that owns the response
//  z          out  16  sum, x + y mod 2^16
//  sign       out  1   z[15]
//  zero       out  1   z == 0
//  parity     out  1   1 when z has an even number of ones (~^z)
//  carry      out  1   bit 16 of the unsigned 17-bit sum
//  overflow   out  1   signed overflow: operands share a sign and z[15] differs from it
// BEHAVIOUR
//  Reset values
//  - rst=1 asynchronously clears: rsp_valid=0, rsp_id=0, z=0, all flags=0, priority pointer=PRIO_INIT.
//  - req_ready=0 while rst is asserted.
//  FSM
//  - EMPTY: buffer free.
//  - FULL: rsp_valid=1.
//  Accept rule
//  - can_accept = EMPTY | (FULL & rsp_ready). This gives back-to-back throughput of 1 result/cycle.
//  - req_ready is combinational from req_valid, pointer and can_accept.
//  - Requesters hold operands stable while req_valid=1 and req_ready=0.
//  Grant
//  - If only one request is valid, that requester is granted.
//  - If both are valid, the requester named by the pointer is granted.
//  - The pointer updates only on a grant: it moves to the non-granted requester.
//  - No grant: req_ready=0 and the pointer is unchanged.
//  - Operands are muxed from the granted requester into the adder.
//  - The 17-bit sum and all flags are captured into the response regs at the clock edge ending the accept cycle.
//  Latency
//  - Operands accepted in cycle N produce rsp_valid=1 with data in cycle N+1.
//  Transitions
//  - EMPTY -> FULL on a grant.
//  - FULL -> EMPTY on rsp_ready with no grant.
//  - FULL -> FULL on rsp_ready with a grant (regs reload), or on no rsp_ready (regs hold).
//  Backpressure
//  - While FULL and rsp_ready=0: rsp_id, z and flags stay bit-stable and req_ready=0.
//  Fairness
//  - Under continuous dual requests and rsp_ready=1, grants alternate 0,1,0,1.
//  - Neither requester waits more than one grant.
//  Reset mid-operation
//  - Any buffered response is discarded; no req_ready is issued during reset.
//  - Requesters re-present their operands after reset.
// TESTING
//  1. Reset: rst pulse mid-cycle -> rsp_valid=0, req_ready=00 immediately; z=0000 and all flags 0.
//  2. Flags
//     - Req0 x=8fff, y=8000 -> next cycle rsp_id=0, z=0fff, carry=1, overflow=1, sign=0, zero=0, parity=1.
//     - Req1 x=ffff, y=0001 -> z=0000, zero=1, carry=1, overflow=0, parity=1.
//     - Req1 x=7fff, y=0001 -> z=8000, sign=1, overflow=1, carry=0, parity=0.
//  3. Round-robin: both valid continuously, rsp_ready=1, PRIO_INIT=0 -> req_ready sequence 01,10,01,10; rsp_id alternates 0,1,0,1.
//  4. Backpressure: rsp_ready=0 for 5 cycles with both valid -> req_ready=00 and response stable; raising rsp_ready -> same-cycle grant of the pointer requester.
//  5. Back-to-back single requester: req0 valid 4 cycles with new operands, rsp_ready=1 -> 4 consecutive responses one cycle behind, pointer ends at 1.
//  6. Reset while FULL and req1 waiting: response dropped, pointer returns to PRIO_INIT; first post-reset dual request grants PRIO_INIT.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 16-bit flag-producing adder between two requesters.
// The result lands in a single-entry response buffer held under valid/ready backpressure.
module alu_share_arbiter #(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] x0,
  input  logic [15:0] y0,
  input  logic [15:0] x1,
  input  logic [15:0] y1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] z,
  output logic        sign,
  output logic        zero,
  output logic        parity,
  output logic        carry,
  output logic        overflow
);

  localparam int unsigned W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           ptr;
  logic           ptr_nxt;
  logic           can_accept;
  logic           grant;
  logic           grant_id;
  logic [W-1:0]   op_x;
  logic [W-1:0]   op_y;
  logic [W:0]     sum;

  // Grant selection, next state and pointer update
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    grant_id   = ptr;
    grant      = 1'b0;
    req_ready  = 2'b00;
    can_accept = ~rst & ((state == EMPTY) | rsp_ready);

    unique case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      default: grant_id = ptr;
    endcase

    grant = can_accept & (|req_valid);

    if (grant) begin
      req_ready = grant_id ? 2'b10 : 2'b01;
      ptr_nxt   = ~grant_id;
    end

    unique case (state)
      EMPTY: if (grant) state_nxt = FULL;
      FULL:  if (rsp_ready && !grant) state_nxt = EMPTY;
    endcase
  end

  // Operand mux into the shared adder
  always_comb begin
    op_x = grant_id ? x1 : x0;
    op_y = grant_id ? y1 : y0;
    sum  = {1'b0, op_x} + {1'b0, op_y};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      ptr   <= PRIO_INIT;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Response buffer reloads only on a grant; otherwise it holds bit-stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id   <= 1'b0;
      z        <= '0;
      sign     <= 1'b0;
      zero     <= 1'b0;
      parity   <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (grant) begin
      rsp_id   <= grant_id;
      z        <= sum[W-1:0];
      sign     <= sum[W-1];
      zero     <= (sum[W-1:0] == '0);
      parity   <= ~^sum[W-1:0];
      carry    <= sum[W];
      overflow <= (op_x[W-1] == op_y[W-1]) & (sum[W-1] != op_x[W-1]);
    end
  end

  assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: per-cycle scoreboard against a behavioural model,
// plus directed vectors with hand-computed expectations.
module tb_alu_share_arbiter;

  localparam logic PRIO = 1'b0;

  typedef struct packed {
    logic [15:0] z;
    logic        sign;
    logic        zero;
    logic        parity;
    logic        carry;
    logic        overflow;
  } rsp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] x0, y0, x1, y1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] z;
  logic        sign, zero, parity, carry, overflow;

  int checks = 0;
  int errors = 0;

  // Model state
  logic        m_ptr;
  logic        m_bv;
  logic        m_bid;
  rsp_t        m_rsp;
  logic [1:0]  m_rr;
  logic        m_g;

  alu_share_arbiter #(.PRIO_INIT(PRIO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .z(z),
    .sign(sign), .zero(zero), .parity(parity), .carry(carry), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain-arithmetic adder reference
  function automatic rsp_t add_ref(input int unsigned a, input int unsigned b);
    rsp_t        r;
    int unsigned s;
    int unsigned zz;
    int unsigned n;
    s  = a + b;
    zz = s % 65536;
    n  = 0;
    for (int i = 0; i < 16; i++) n += (zz >> i) & 1;
    r.z        = 16'(zz);
    r.sign     = (zz >= 32768);
    r.zero     = (zz == 0);
    r.parity   = (n % 2 == 0);
    r.carry    = (s >= 65536);
    r.overflow = ((a >= 32768) == (b >= 32768)) && ((a >= 32768) != (zz >= 32768));
    return r;
  endfunction

  // Scoreboard: check this cycle's outputs, then advance the model past the coming edge
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 32'(0));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      m_ptr = PRIO;
      m_bv  = 1'b0;
      m_bid = 1'b0;
    end else begin
      m_rr = 2'b00;
      m_g  = 1'b0;
      if (!(m_bv && !rsp_ready) && req_valid != 2'b00) begin
        m_g  = (req_valid == 2'b11) ? m_ptr : req_valid[1];
        m_rr = m_g ? 2'b10 : 2'b01;
      end
      chk("req_ready", 32'(req_ready), 32'(m_rr));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_bv));
      if (m_bv) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_bid));
        chk("rsp_data", 32'({z, sign, zero, parity, carry, overflow}), 32'(m_rsp));
      end
      if (m_rr != 2'b00) begin
        m_bv  = 1'b1;
        m_bid = m_g;
        m_rsp = m_g ? add_ref(32'(x1), 32'(y1)) : add_ref(32'(x0), 32'(y0));
        m_ptr = ~m_g;
      end else if (m_bv && rsp_ready) begin
        m_bv = 1'b0;
      end
    end
  end

  task automatic cyc(input logic [1:0] v, input logic rr,
                     input logic [15:0] a0, input logic [15:0] b0,
                     input logic [15:0] a1, input logic [15:0] b1);
    @(posedge clk);
    #1;
    req_valid = v;
    rsp_ready = rr;
    x0 = a0; y0 = b0; x1 = a1; y1 = b1;
    @(negedge clk);
  endtask

  // Mid-cycle asynchronous reset pulse spanning one negedge
  task automatic pulse_rst();
    @(posedge clk);
    #3;
    rst = 1'b1;
    req_valid = 2'b00;
    #1;
    chk("async_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("async_req_ready", 32'(req_ready), 32'(0));
    chk("async_z", 32'(z), 32'(0));
    chk("async_flags", 32'({sign, zero, parity, carry, overflow}), 32'(0));
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  logic [1:0] rr_seq [5];

  initial begin
    rst = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    #1 rst = 1'b1;
    #2;
    chk("init_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("init_z", 32'(z), 32'(0));
    chk("init_flags", 32'({sign, zero, parity, carry, overflow}), 32'(0));
    chk("init_req_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    // Flag vectors
    cyc(2'b01, 1'b1, 16'h8fff, 16'h8000, 16'h0000, 16'h0000);
    chk("f1_req_ready", 32'(req_ready), 32'(2'b01));
    cyc(2'b10, 1'b1, 16'h0000, 16'h0000, 16'hffff, 16'h0001);
    chk("f1_id", 32'(rsp_id), 32'(0));
    chk("f1_z", 32'(z), 32'(16'h0fff));
    chk("f1_flags", 32'({sign, zero, parity, carry, overflow}), 32'(5'b00111));
    chk("f2_req_ready", 32'(req_ready), 32'(2'b10));
    cyc(2'b10, 1'b1, 16'h0000, 16'h0000, 16'h7fff, 16'h0001);
    chk("f2_id", 32'(rsp_id), 32'(1));
    chk("f2_z", 32'(z), 32'(16'h0000));
    chk("f2_flags", 32'({sign, zero, parity, carry, overflow}), 32'(5'b01110));
    cyc(2'b00, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    chk("f3_z", 32'(z), 32'(16'h8000));
    chk("f3_flags", 32'({sign, zero, parity, carry, overflow}), 32'(5'b10001));
    cyc(2'b00, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    chk("f_drain", 32'(rsp_valid), 32'(0));

    // Round-robin under continuous dual requests
    pulse_rst();
    rr_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    for (int k = 0; k < 5; k++) begin
      cyc(2'b11, 1'b1, 16'(16'h0100 + k), 16'h0010, 16'(16'h2000 + k), 16'h0003);
      chk("rr_req_ready", 32'(req_ready), 32'(rr_seq[k]));
      if (k >= 1) chk("rr_rsp_id", 32'(rsp_id), 32'((k - 1) % 2));
    end

    // Backpressure: buffer holds req0's 0x0104+0x0010
    for (int k = 0; k < 5; k++) begin
      cyc(2'b11, 1'b0, 16'h0104, 16'h0010, 16'h2004, 16'h0003);
      chk("bp_req_ready", 32'(req_ready), 32'(0));
      chk("bp_hold", 32'({rsp_valid, rsp_id, z, sign, zero, parity, carry, overflow}),
          32'({1'b1, 1'b0, 16'h0114, 5'b00000}));
    end
    cyc(2'b11, 1'b1, 16'h0104, 16'h0010, 16'h2004, 16'h0003);
    chk("bp_release", 32'(req_ready), 32'(2'b10));

    // Back-to-back single requester
    for (int j = 0; j < 4; j++) begin
      cyc(2'b01, 1'b1, 16'(16'h0010 * (j + 1)), 16'h0001, 16'h0000, 16'h0000);
      chk("b2b_req_ready", 32'(req_ready), 32'(2'b01));
      if (j == 0) chk("b2b_prev", 32'({rsp_id, z}), 32'({1'b1, 16'h2007}));
      else        chk("b2b_rsp", 32'({rsp_id, z}), 32'({1'b0, 16'(16'h0010 * j + 1)}));
    end
    cyc(2'b11, 1'b1, 16'h0050, 16'h0001, 16'h2000, 16'h0003);
    chk("b2b_last", 32'({rsp_id, z}), 32'({1'b0, 16'h0041}));
    chk("b2b_ptr", 32'(req_ready), 32'(2'b10));

    // Reset while FULL with req1 waiting
    cyc(2'b10, 1'b0, 16'h0050, 16'h0001, 16'h1234, 16'h0001);
    chk("r6_full", 32'({rsp_valid, rsp_id, z}), 32'({1'b1, 1'b1, 16'h2003}));
    chk("r6_wait", 32'(req_ready), 32'(0));
    pulse_rst();
    cyc(2'b11, 1'b1, 16'h0050, 16'h0001, 16'h1234, 16'h0001);
    chk("r6_first", 32'(req_ready), 32'(2'b01));
    cyc(2'b00, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    chk("r6_rsp", 32'({rsp_valid, rsp_id, z}), 32'({1'b1, 1'b0, 16'h0051}));
    cyc(2'b00, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    cyc(2'b00, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
